// File: rtl/dcf77_pkg.sv
// Shared types, frame bit positions and calendar helper for the DCF77 clock.
// The optional calendar is selected with DCF77_CLOCK_DATE_EN.
package dcf77_pkg;

    typedef logic [6:0] bcd_sec_t;
    typedef logic [6:0] bcd_min_t;
    typedef logic [5:0] bcd_hour_t;
    typedef logic [5:0] bcd_day_t;
    typedef logic [4:0] bcd_month_t;
    typedef logic [7:0] bcd_year_t;

    localparam int CEST_BIT  = 17;
    localparam int MIN_LSB   = 21;
    localparam int MIN_MSB   = 27;
    localparam int HOUR_LSB  = 29;
    localparam int HOUR_MSB  = 34;
    localparam int DAY_LSB   = 36;
    localparam int DAY_MSB   = 41;
    localparam int WDAY_LSB  = 42;
    localparam int WDAY_MSB  = 44;
    localparam int MONTH_LSB = 45;
    localparam int MONTH_MSB = 49;
    localparam int YEAR_LSB  = 50;
    localparam int YEAR_MSB  = 57;

    // Leap test works directly on BCD digits: multiples of 4 within 00..99.
    function automatic bcd_day_t days_in_month(input bcd_month_t month, input bcd_year_t year);
        logic leap;
        if (year[4]) begin
            leap = (year[3:0] == 4'h2) || (year[3:0] == 4'h6);
        end else begin
            leap = (year[3:0] == 4'h0) || (year[3:0] == 4'h4) || (year[3:0] == 4'h8);
        end
        case (month)
            5'h02:                      days_in_month = leap ? 6'h29 : 6'h28;
            5'h04, 5'h06, 5'h09, 5'h11: days_in_month = 6'h30;
            default:                    days_in_month = 6'h31;
        endcase
    endfunction

endpackage

// File: rtl/dcf77_bcd_counter.sv
// Loadable BCD counter with programmable min/max and a combinational carry,
// so a chain of these resolves a full rollover in a single enabled cycle.
module dcf77_bcd_counter #(
    parameter int W = 8
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_clk_en,
    input  logic         i_inc,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    input  logic [W-1:0] i_min_val,
    input  logic [W-1:0] i_max_val,
    output logic [W-1:0] o_val,
    output logic         o_carry
);

    logic [W-1:0] r_val;
    logic [7:0]   w_ext;
    logic [7:0]   w_bcd_inc;
    logic [W-1:0] w_next;
    logic         w_unused;

    // Next value: wrap to min at max, otherwise a BCD digit increment.
    always_comb begin
        w_ext          = 8'h00;
        w_ext[W-1:0]   = r_val;
        if (w_ext[3:0] == 4'h9) begin
            w_bcd_inc = {w_ext[7:4] + 4'h1, 4'h0};
        end else begin
            w_bcd_inc = {w_ext[7:4], w_ext[3:0] + 4'h1};
        end
        if (r_val == i_max_val) begin
            w_next = i_min_val;
        end else begin
            w_next = w_bcd_inc[W-1:0];
        end
    end

    assign w_unused = ^w_bcd_inc;
    assign o_carry  = i_inc & ~i_load & (r_val == i_max_val);
    assign o_val    = r_val;

    // Counter register; load has priority over increment.
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_val <= i_min_val;
        end else if (i_clk_en) begin
            if (i_load) begin
                r_val <= i_load_val;
            end else if (i_inc) begin
                r_val <= w_next;
            end
        end
    end

endmodule

// File: rtl/dcf77_clock.sv
// Free-running BCD clock resynchronised by DCF77 frames.
// Define DCF77_CLOCK_DATE_EN to include the calendar (day/wday/month/year).
module dcf77_clock
    import dcf77_pkg::*;
#(
    parameter int SYNC_OFFSET   = 4,
    parameter int TICKS_PER_SEC = 100,
    parameter int HOLDOVER_MIN  = 60
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_clk_en,
    input  logic [58:0] i_data_hold,
    input  logic        i_sync,
    output bcd_sec_t    o_sec,
    output bcd_min_t    o_min,
    output bcd_hour_t   o_hour,
    output bcd_day_t    o_day,
    output logic [2:0]  o_wday,
    output bcd_month_t  o_month,
    output bcd_year_t   o_year,
    output logic        o_cest,
    output logic        o_sec_tick,
    output logic        o_time_valid,
    output logic        o_locked
);

    localparam int PW = $clog2(TICKS_PER_SEC);
    localparam int HW = $clog2(HOLDOVER_MIN + 1);
    localparam logic [PW-1:0] PRESC_MAX  = PW'(TICKS_PER_SEC - 1);
    localparam logic [PW-1:0] PRESC_LOAD = PW'(SYNC_OFFSET);
    localparam logic [HW-1:0] HOLD_MAX   = HW'(HOLDOVER_MIN);
    localparam logic [HW-1:0] HOLD_LAST  = HW'(HOLDOVER_MIN - 1);

    logic [PW-1:0] r_presc;
    logic [HW-1:0] r_hold;
    logic          r_cest;
    logic          r_sec_tick;
    logic          r_time_valid;
    logic          r_locked;

    logic w_load;
    logic w_sec_inc;
    logic w_sec_carry;
    logic w_min_carry;
    logic w_hour_carry;
    logic w_unused;

    assign w_load    = i_clk_en & i_sync;
    assign w_sec_inc = i_clk_en & ~i_sync & (r_presc == PRESC_MAX);

    dcf77_bcd_counter #(.W(7)) u_sec (
        .i_clk(i_clk), .i_rst(i_rst), .i_clk_en(i_clk_en),
        .i_inc(w_sec_inc), .i_load(w_load), .i_load_val(7'h00),
        .i_min_val(7'h00), .i_max_val(7'h59), .o_val(o_sec), .o_carry(w_sec_carry)
    );

    dcf77_bcd_counter #(.W(7)) u_min (
        .i_clk(i_clk), .i_rst(i_rst), .i_clk_en(i_clk_en),
        .i_inc(w_sec_carry), .i_load(w_load), .i_load_val(i_data_hold[MIN_MSB:MIN_LSB]),
        .i_min_val(7'h00), .i_max_val(7'h59), .o_val(o_min), .o_carry(w_min_carry)
    );

    dcf77_bcd_counter #(.W(6)) u_hour (
        .i_clk(i_clk), .i_rst(i_rst), .i_clk_en(i_clk_en),
        .i_inc(w_min_carry), .i_load(w_load), .i_load_val(i_data_hold[HOUR_MSB:HOUR_LSB]),
        .i_min_val(6'h00), .i_max_val(6'h23), .o_val(o_hour), .o_carry(w_hour_carry)
    );

`ifdef DCF77_CLOCK_DATE_EN
    logic     w_day_carry;
    logic     w_month_carry;
    logic     w_year_carry;
    logic     w_wday_carry;
    bcd_day_t w_mdays;

    assign w_mdays = days_in_month(o_month, o_year);

    dcf77_bcd_counter #(.W(6)) u_day (
        .i_clk(i_clk), .i_rst(i_rst), .i_clk_en(i_clk_en),
        .i_inc(w_hour_carry), .i_load(w_load), .i_load_val(i_data_hold[DAY_MSB:DAY_LSB]),
        .i_min_val(6'h01), .i_max_val(w_mdays), .o_val(o_day), .o_carry(w_day_carry)
    );

    dcf77_bcd_counter #(.W(3)) u_wday (
        .i_clk(i_clk), .i_rst(i_rst), .i_clk_en(i_clk_en),
        .i_inc(w_hour_carry), .i_load(w_load), .i_load_val(i_data_hold[WDAY_MSB:WDAY_LSB]),
        .i_min_val(3'd1), .i_max_val(3'd7), .o_val(o_wday), .o_carry(w_wday_carry)
    );

    dcf77_bcd_counter #(.W(5)) u_month (
        .i_clk(i_clk), .i_rst(i_rst), .i_clk_en(i_clk_en),
        .i_inc(w_day_carry), .i_load(w_load), .i_load_val(i_data_hold[MONTH_MSB:MONTH_LSB]),
        .i_min_val(5'h01), .i_max_val(5'h12), .o_val(o_month), .o_carry(w_month_carry)
    );

    dcf77_bcd_counter #(.W(8)) u_year (
        .i_clk(i_clk), .i_rst(i_rst), .i_clk_en(i_clk_en),
        .i_inc(w_month_carry), .i_load(w_load), .i_load_val(i_data_hold[YEAR_MSB:YEAR_LSB]),
        .i_min_val(8'h00), .i_max_val(8'h99), .o_val(o_year), .o_carry(w_year_carry)
    );

    assign w_unused = ^{w_year_carry, w_wday_carry, i_data_hold[58], i_data_hold[35],
                        i_data_hold[28], i_data_hold[20:18], i_data_hold[16:0]};
`else
    assign o_day    = 6'h01;
    assign o_wday   = 3'd1;
    assign o_month  = 5'h01;
    assign o_year   = 8'h00;
    assign w_unused = ^{w_hour_carry, i_data_hold[58:35], i_data_hold[28],
                        i_data_hold[20:18], i_data_hold[16:0]};
`endif

    // Prescaler, holdover supervision and status flags.
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_presc      <= '0;
            r_hold       <= '0;
            r_cest       <= 1'b0;
            r_sec_tick   <= 1'b0;
            r_time_valid <= 1'b0;
            r_locked     <= 1'b0;
        end else begin
            r_sec_tick <= w_sec_inc;
            if (i_clk_en) begin
                if (i_sync) begin
                    r_presc      <= PRESC_LOAD;
                    r_hold       <= '0;
                    r_cest       <= i_data_hold[CEST_BIT];
                    r_time_valid <= 1'b1;
                    r_locked     <= 1'b1;
                end else begin
                    r_presc <= (r_presc == PRESC_MAX) ? '0 : r_presc + 1'b1;
                    // One holdover count per elapsed minute, saturating.
                    if (w_sec_carry && (r_hold != HOLD_MAX)) begin
                        r_hold <= r_hold + 1'b1;
                        if (r_hold == HOLD_LAST) begin
                            r_locked <= 1'b0;
                        end
                    end
                end
            end
        end
    end

    assign o_cest       = r_cest;
    assign o_sec_tick   = r_sec_tick;
    assign o_time_valid = r_time_valid;
    assign o_locked     = r_locked;

endmodule

// File: tb/tb_dcf77_clock.sv
// Self-checking bench for dcf77_clock: vector table, corner sequences and a
// randomized phase checked against a behavioural calendar model.
module tb_dcf77_clock;

    localparam int TPS  = 100;
    localparam int OFF  = 4;
    localparam int HOLD = 2;
`ifdef DCF77_CLOCK_DATE_EN
    localparam bit DATE_EN = 1'b1;
`else
    localparam bit DATE_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n, clk_en, sync;
    logic [58:0] dh;
    logic [6:0]  t_sec, t_min;
    logic [5:0]  t_hour, t_day;
    logic [2:0]  t_wday;
    logic [4:0]  t_month;
    logic [7:0]  t_year;
    logic        t_cest, t_tick, t_valid, t_locked;

    always #5 clk = ~clk;

    dcf77_clock #(.SYNC_OFFSET(OFF), .TICKS_PER_SEC(TPS), .HOLDOVER_MIN(HOLD)) dut (
        .i_clk(clk), .i_rst(rst_n), .i_clk_en(clk_en), .i_data_hold(dh), .i_sync(sync),
        .o_sec(t_sec), .o_min(t_min), .o_hour(t_hour), .o_day(t_day), .o_wday(t_wday),
        .o_month(t_month), .o_year(t_year), .o_cest(t_cest), .o_sec_tick(t_tick),
        .o_time_valid(t_valid), .o_locked(t_locked)
    );

    typedef struct {
        int mi, hr, dy, wd, mo, yr, cs, ticks, gap;
        int e_sec, e_min, e_hr, e_dy, e_wd, e_mo, e_yr, e_pulses, e_first;
    } vec_t;

    int n_cmp = 0, n_err = 0;
    int m_presc, m_sec, m_min, m_hour, m_day, m_wday, m_month, m_year, m_hold;
    bit m_cest, m_tick, m_valid, m_locked;
    int pulses, first_tick, wide, tick_idx;
    logic prev_tick;

    function automatic int bcd2int(input logic [7:0] b);
        return int'(b[7:4]) * 10 + int'(b[3:0]);
    endfunction

    function automatic int int2bcd(input int v);
        return (v / 10) * 16 + (v % 10);
    endfunction

    function automatic int mdays(input int mo, input int yr);
        if (mo == 2) return (yr % 4 == 0) ? 29 : 28;
        if (mo == 4 || mo == 6 || mo == 9 || mo == 11) return 30;
        return 31;
    endfunction

    function automatic logic [58:0] mk_frame(input int mi, hr, dy, wd, mo, yr, cs,
                                             input logic [58:0] noise);
        logic [58:0] f;
        f = noise;
        f[27:21] = mi[6:0];
        f[34:29] = hr[5:0];
        f[41:36] = dy[5:0];
        f[44:42] = wd[2:0];
        f[49:45] = mo[4:0];
        f[57:50] = yr[7:0];
        f[17]    = cs[0];
        return f;
    endfunction

    function automatic logic [58:0] rnd_noise();
        logic [63:0] r;
        r = {$urandom, $urandom};
        return r[58:0];
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic check_model(input string nm);
        chk({nm, ".sec"},   int'(t_sec),    int2bcd(m_sec));
        chk({nm, ".min"},   int'(t_min),    int2bcd(m_min));
        chk({nm, ".hour"},  int'(t_hour),   int2bcd(m_hour));
        chk({nm, ".day"},   int'(t_day),    int2bcd(m_day));
        chk({nm, ".wday"},  int'(t_wday),   m_wday);
        chk({nm, ".month"}, int'(t_month),  int2bcd(m_month));
        chk({nm, ".year"},  int'(t_year),   int2bcd(m_year));
        chk({nm, ".cest"},  int'(t_cest),   int'(m_cest));
        chk({nm, ".tick"},  int'(t_tick),   int'(m_tick));
        chk({nm, ".valid"}, int'(t_valid),  int'(m_valid));
        chk({nm, ".lock"},  int'(t_locked), int'(m_locked));
    endtask

    // Behavioural model: one call per clock edge with the inputs just applied.
    task automatic model_step();
        m_tick = 1'b0;
        if (!rst_n) begin
            m_presc = 0; m_sec = 0; m_min = 0; m_hour = 0; m_hold = 0;
            m_day = 1; m_wday = 1; m_month = 1; m_year = 0;
            m_cest = 1'b0; m_valid = 1'b0; m_locked = 1'b0;
        end else if (clk_en && sync) begin
            m_min  = bcd2int({1'b0, dh[27:21]});
            m_hour = bcd2int({2'b00, dh[34:29]});
            m_cest = dh[17];
            if (DATE_EN) begin
                m_day   = bcd2int({2'b00, dh[41:36]});
                m_wday  = int'(dh[44:42]);
                m_month = bcd2int({3'b000, dh[49:45]});
                m_year  = bcd2int(dh[57:50]);
            end
            m_sec = 0; m_presc = OFF; m_hold = 0; m_valid = 1'b1; m_locked = 1'b1;
        end else if (clk_en) begin
            if (m_presc == TPS - 1) begin
                m_presc = 0;
                m_tick  = 1'b1;
                m_sec++;
                if (m_sec == 60) begin
                    m_sec = 0;
                    if (m_hold < HOLD) begin
                        m_hold++;
                        if (m_hold == HOLD) m_locked = 1'b0;
                    end
                    m_min++;
                    if (m_min == 60) begin
                        m_min = 0;
                        m_hour++;
                        if (m_hour == 24) begin
                            m_hour = 0;
                            if (DATE_EN) begin
                                m_wday = (m_wday % 7) + 1;
                                m_day++;
                                if (m_day > mdays(m_month, m_year)) begin
                                    m_day = 1;
                                    m_month++;
                                    if (m_month > 12) begin
                                        m_month = 1;
                                        m_year  = (m_year + 1) % 100;
                                    end
                                end
                            end
                        end
                    end
                end
            end else begin
                m_presc++;
            end
        end
    endtask

    task automatic cycle(input logic en, input logic sy, input logic [58:0] d);
        @(negedge clk);
        clk_en = en; sync = sy; dh = d;
        @(posedge clk);
        model_step();
        #1;
        if (t_tick) begin
            pulses++;
            if (first_tick == 0) first_tick = tick_idx;
            if (prev_tick) wide++;
        end
        prev_tick = t_tick;
        if (m_tick) check_model("tick");
    endtask

    task automatic do_sync(input logic [58:0] f);
        tick_idx = 0; pulses = 0; first_tick = 0; wide = 0;
        cycle(1'b1, 1'b1, f);
    endtask

    task automatic run(input int ticks, input int gap);
        for (int t = 1; t <= ticks; t++) begin
            for (int g = 0; g < gap; g++) cycle(1'b0, 1'b0, '0);
            tick_idx = t;
            cycle(1'b1, 1'b0, '0);
        end
    endtask

    vec_t vecs[8];
    vec_t v;

    initial begin
        vecs[0] = '{'h37, 'h14, 'h05, 3, 'h06, 'h24, 1,    0, 0, 'h00, 'h37, 'h14, 'h05, 3, 'h06, 'h24,  0,  0};
        vecs[1] = '{'h37, 'h14, 'h05, 3, 'h06, 'h24, 1, 6000, 1, 'h00, 'h38, 'h14, 'h05, 3, 'h06, 'h24, 60, 96};
        vecs[2] = '{'h59, 'h23, 'h28, 3, 'h02, 'h24, 0, 6000, 0, 'h00, 'h00, 'h00, 'h29, 4, 'h02, 'h24, 60, 96};
        vecs[3] = '{'h59, 'h23, 'h28, 3, 'h02, 'h23, 0, 6000, 0, 'h00, 'h00, 'h00, 'h01, 4, 'h03, 'h23, 60, 96};
        vecs[4] = '{'h59, 'h23, 'h31, 7, 'h12, 'h99, 1, 6000, 0, 'h00, 'h00, 'h00, 'h01, 1, 'h01, 'h00, 60, 96};
        vecs[5] = '{'h59, 'h23, 'h28, 1, 'h02, 'h10, 0, 6000, 0, 'h00, 'h00, 'h00, 'h01, 2, 'h03, 'h10, 60, 96};
        vecs[6] = '{'h59, 'h23, 'h30, 5, 'h04, 'h21, 1, 6000, 0, 'h00, 'h00, 'h00, 'h01, 6, 'h05, 'h21, 60, 96};
        vecs[7] = '{'h59, 'h23, 'h28, 6, 'h02, 'h12, 0, 6000, 0, 'h00, 'h00, 'h00, 'h29, 7, 'h02, 'h12, 60, 96};

        rst_n = 1'b0; clk_en = 1'b0; sync = 1'b0; dh = '0;
        prev_tick = 1'b0; tick_idx = 0; pulses = 0; first_tick = 0; wide = 0;
        cycle(1'b0, 1'b0, '0);
        cycle(1'b1, 1'b1, rnd_noise());
        chk("rst.sec", int'(t_sec), 'h00);     chk("rst.min", int'(t_min), 'h00);
        chk("rst.hour", int'(t_hour), 'h00);   chk("rst.day", int'(t_day), 'h01);
        chk("rst.wday", int'(t_wday), 1);      chk("rst.month", int'(t_month), 'h01);
        chk("rst.year", int'(t_year), 'h00);   chk("rst.cest", int'(t_cest), 0);
        chk("rst.tick", int'(t_tick), 0);      chk("rst.valid", int'(t_valid), 0);
        chk("rst.lock", int'(t_locked), 0);
        rst_n = 1'b1;

        for (int i = 0; i < 8; i++) begin
            v = vecs[i];
            do_sync(mk_frame(v.mi, v.hr, v.dy, v.wd, v.mo, v.yr, v.cs, rnd_noise()));
            run(v.ticks, v.gap);
            chk($sformatf("v%0d.sec", i),   int'(t_sec),   v.e_sec);
            chk($sformatf("v%0d.min", i),   int'(t_min),   v.e_min);
            chk($sformatf("v%0d.hour", i),  int'(t_hour),  v.e_hr);
            chk($sformatf("v%0d.day", i),   int'(t_day),   DATE_EN ? v.e_dy : 'h01);
            chk($sformatf("v%0d.wday", i),  int'(t_wday),  DATE_EN ? v.e_wd : 1);
            chk($sformatf("v%0d.month", i), int'(t_month), DATE_EN ? v.e_mo : 'h01);
            chk($sformatf("v%0d.year", i),  int'(t_year),  DATE_EN ? v.e_yr : 'h00);
            chk($sformatf("v%0d.cest", i),  int'(t_cest),  v.cs);
            chk($sformatf("v%0d.valid", i), int'(t_valid), 1);
            chk($sformatf("v%0d.lock", i),  int'(t_locked), 1);
            chk($sformatf("v%0d.pulses", i), pulses, v.e_pulses);
            chk($sformatf("v%0d.first", i), first_tick, v.e_first);
            chk($sformatf("v%0d.wide", i),  wide, 0);
            check_model($sformatf("v%0d", i));
        end

        // sync lands on the very tick the prescaler would wrap
        do_sync(mk_frame('h00, 'h10, 'h11, 2, 'h03, 'h24, 0, rnd_noise()));
        for (int i = 0; i < TPS + 4 && m_presc != TPS - 1; i++) cycle(1'b1, 1'b0, '0);
        do_sync(mk_frame('h15, 'h08, 'h12, 5, 'h03, 'h24, 0, rnd_noise()));
        chk("wrap.sec", int'(t_sec), 'h00);
        chk("wrap.tick", int'(t_tick), 0);
        chk("wrap.min", int'(t_min), 'h15);
        check_model("wrap");

        // holdover: the HOLD-th minute rollover after sync drops lock
        run(HOLD * 60 * TPS - OFF - 1, 0);
        chk("hold.pre_lock", int'(t_locked), 1);
        run(1, 0);
        chk("hold.lock", int'(t_locked), 0);
        chk("hold.valid", int'(t_valid), 1);
        chk("hold.min", int'(t_min), int2bcd(15 + HOLD));
        chk("hold.sec", int'(t_sec), 'h00);
        run(TPS, 0);
        chk("hold.run_sec", int'(t_sec), 'h01);
        chk("hold.still_unlocked", int'(t_locked), 0);
        check_model("hold");

        // randomized enables and frames
        for (int i = 0; i < 4000; i++) begin
            logic en, sy;
            en = ($urandom_range(0, 3) != 0);
            sy = en && ($urandom_range(0, 299) == 0);
            if (sy) begin
                cycle(1'b1, 1'b1, mk_frame(int2bcd($urandom_range(0, 59)), int2bcd($urandom_range(0, 23)),
                      int2bcd($urandom_range(1, 28)), $urandom_range(1, 7), int2bcd($urandom_range(1, 12)),
                      int2bcd($urandom_range(0, 99)), $urandom_range(0, 1), rnd_noise()));
                check_model("rnd.sync");
            end else begin
                cycle(en, 1'b0, '0);
            end
        end

        // reset mid-count with clk_en low
        rst_n = 1'b0;
        cycle(1'b0, 1'b0, '0);
        chk("mrst.sec", int'(t_sec), 'h00);    chk("mrst.min", int'(t_min), 'h00);
        chk("mrst.hour", int'(t_hour), 'h00);  chk("mrst.day", int'(t_day), 'h01);
        chk("mrst.wday", int'(t_wday), 1);     chk("mrst.month", int'(t_month), 'h01);
        chk("mrst.year", int'(t_year), 'h00);  chk("mrst.cest", int'(t_cest), 0);
        chk("mrst.valid", int'(t_valid), 0);   chk("mrst.lock", int'(t_locked), 0);
        rst_n = 1'b1;
        run(TPS, 0);
        check_model("post_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
